fetch_unit: RTL and testbench

//  Instruction fetch stage placed directly upstream of the decode/control stage.
//  - Holds the PC and runs a req/ready handshake with instruction memory.
//  - Presents the fetched word, its PC and the split op/funct fields to decode,
//    one registered instruction per cycle when not stalled.
//  - Redirects on taken branch or jump; a one-entry skid buffer absorbs a

---
 rtl/fetch_unit_if.sv | 28 ++
 rtl/fetch_unit.sv | 149 ++++++++++++++
 tb/tb_fetch_unit.sv | 388 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction memory request/response bus
// Purpose: groups the fetch stage's instruction memory handshake.
// Signals:
//   imem_req    request valid; imem_addr is stable while high
//   imem_addr   word address of the request
//   imem_ready  response strobe; imem_rdata is valid this cycle
//   imem_rdata  fetched instruction word
// Modports: master = fetch stage, slave = instruction memory.
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with one-entry skid buffer and redirect
// Purpose: holds the PC, fetches from instruction memory and presents one
//   registered instruction (word, PC, op, funct) per cycle to decode.
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   imem                instruction memory bus (master side)
//   stall_i             decode not accepting: hold outputs
//   redirect_valid_i    one-cycle taken branch/jump pulse
//   redirect_target_i   new PC (bits [1:0] ignored)
//   instr_o             registered instruction
//   instr_valid_o       outputs below are meaningful
//   instr_pc_o          PC of instr_o
//   op_o, funct_o       instr_o[31:26], instr_o[5:0]
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master imem,
    input  logic         stall_i,
    input  logic         redirect_valid_i,
    input  logic [31:0]  redirect_target_i,
    output logic [31:0]  instr_o,
    output logic         instr_valid_o,
    output logic [31:0]  instr_pc_o,
    output logic [5:0]   op_o,
    output logic [5:0]   funct_o
);
    localparam logic [0:0] ST_REQ  = 1'b0;
    localparam logic [0:0] ST_SKID = 1'b1;

    logic [0:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        drop_q, drop_d;
    logic [31:0] pend_target_q, pend_target_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic [31:0] instr_q, instr_d;
    logic        instr_valid_q, instr_valid_d;
    logic [31:0] instr_pc_q, instr_pc_d;

    logic        slot_free;
    logic [31:0] target_aligned;

    assign slot_free      = !instr_valid_q || !stall_i;
    assign target_aligned = redirect_target_i & ~32'h3;

    // Gating with rst keeps the request low for the whole reset, so an
    // in-flight response cannot be mistaken for a new one.
    assign imem.imem_req  = (state_q == ST_REQ) && !rst;
    assign imem.imem_addr = pc_q;

    assign instr_o       = instr_q;
    assign instr_valid_o = instr_valid_q;
    assign instr_pc_o    = instr_pc_q;
    assign op_o          = instr_q[31:26];
    assign funct_o       = instr_q[5:0];

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        drop_d        = drop_q;
        pend_target_d = pend_target_q;
        skid_instr_d  = skid_instr_q;
        skid_pc_d     = skid_pc_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;

        // Decode consumed the current instruction: bubble unless refilled below.
        if (!stall_i) begin
            instr_valid_d = 1'b0;
        end

        case (state_q)
            ST_REQ: begin
                if (imem.imem_ready) begin
                    if (drop_q) begin
                        // Response belongs to the pre-redirect stream.
                        pc_d   = pend_target_q;
                        drop_d = 1'b0;
                    end else if (slot_free) begin
                        instr_d       = imem.imem_rdata;
                        instr_pc_d    = pc_q;
                        instr_valid_d = 1'b1;
                        pc_d          = pc_q + 32'd4;
                    end else begin
                        skid_instr_d = imem.imem_rdata;
                        skid_pc_d    = pc_q;
                        pc_d         = pc_q + 32'd4;
                        state_d      = ST_SKID;
                    end
                end
            end
            default: begin
                if (!stall_i) begin
                    instr_d       = skid_instr_q;
                    instr_pc_d    = skid_pc_q;
                    instr_valid_d = 1'b1;
                    skid_instr_d  = 32'h0;
                    skid_pc_d     = 32'h0;
                    state_d       = ST_REQ;
                end
            end
        endcase

        // Redirect overrides everything, including a stalled output slot.
        if (redirect_valid_i) begin
            instr_d       = instr_q;
            instr_pc_d    = instr_pc_q;
            instr_valid_d = 1'b0;
            skid_instr_d  = 32'h0;
            skid_pc_d     = 32'h0;
            state_d       = ST_REQ;
            if (state_q == ST_SKID || imem.imem_ready) begin
                pc_d   = target_aligned;
                drop_d = 1'b0;
            end else begin
                // Request still outstanding: let it finish, then discard it.
                pend_target_d = target_aligned;
                drop_d        = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_REQ;
            pc_q          <= RESET_PC;
            drop_q        <= 1'b0;
            pend_target_q <= 32'h0;
            skid_instr_q  <= 32'h0;
            skid_pc_q     <= 32'h0;
            instr_q       <= 32'h0;
            instr_valid_q <= 1'b0;
            instr_pc_q    <= 32'h0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            drop_q        <= drop_d;
            pend_target_q <= pend_target_d;
            skid_instr_q  <= skid_instr_d;
            skid_pc_q     <= skid_pc_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            instr_pc_q    <= instr_pc_d;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit
module tb_fetch_unit;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, stall, redirect;
    logic [31:0] target;
    logic [31:0] instr, instr_pc;
    logic        instr_valid;
    logic [5:0]  op, funct;
    fetch_unit_if bus ();

    logic        rst_w;
    logic [31:0] instr_w, instr_pc_w;
    logic        instr_valid_w;
    logic [5:0]  op_w, funct_w;
    fetch_unit_if bus_w ();

    int          n_pass, n_total, lat, cnt, accepted;
    logic [31:0] exp_pc;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .imem(bus), .stall_i(stall),
        .redirect_valid_i(redirect), .redirect_target_i(target),
        .instr_o(instr), .instr_valid_o(instr_valid), .instr_pc_o(instr_pc),
        .op_o(op), .funct_o(funct)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk(clk), .rst(rst_w), .imem(bus_w), .stall_i(1'b0),
        .redirect_valid_i(1'b0), .redirect_target_i(32'h0),
        .instr_o(instr_w), .instr_valid_o(instr_valid_w), .instr_pc_o(instr_pc_w),
        .op_o(op_w), .funct_o(funct_w)
    );

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC3A5_0F1E;
    endfunction

    // Instruction memory: answers after 'lat' idle request cycles, and always
    // leaves one cycle without ready after a response.
    always @(negedge clk) begin
        if (rst) begin
            bus.imem_ready = 1'b0;
            cnt = 0;
        end else if (bus.imem_ready) begin
            bus.imem_ready = 1'b0;
            cnt = 0;
        end else if (bus.imem_req) begin
            if (cnt >= lat) begin
                bus.imem_ready = 1'b1;
                bus.imem_rdata = memf(bus.imem_addr);
            end else begin
                cnt = cnt + 1;
            end
        end else begin
            cnt = 0;
        end
    end

    // Reference stream: decode must see consecutive PCs from reset, restarting
    // at the aligned target after each redirect, each carrying memf(pc).
    task automatic sb_loop();
        logic [31:0] w;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                exp_pc = 32'h0;
            end else begin
                if (instr_valid && !stall) begin
                    w = memf(exp_pc);
                    n_total++;
                    if (instr_pc !== exp_pc || instr !== w)
                        $display("FAIL stream: got pc %h instr %h, want pc %h instr %h", instr_pc, instr, exp_pc, w);
                    else n_pass++;
                    n_total++;
                    if (op !== w[31:26] || funct !== w[5:0])
                        $display("FAIL fields: got op %h funct %h, want op %h funct %h", op, funct, w[31:26], w[5:0]);
                    else n_pass++;
                    exp_pc = exp_pc + 32'd4;
                    accepted++;
                end
                if (redirect) exp_pc = target & ~32'h3;
            end
        end
    endtask

    task automatic do_reset(input int l);
        @(negedge clk);
        #1;
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; lat = l;
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        #1;
        n_total++;
        if ({bus.imem_req, instr_valid} !== 2'b00)
            $display("FAIL reset_req_valid: got %b want 00", {bus.imem_req, instr_valid});
        else n_pass++;
        n_total++;
        if (bus.imem_addr !== 32'h0 || instr !== 32'h0 || instr_pc !== 32'h0 || op !== 6'h0 || funct !== 6'h0)
            $display("FAIL reset_values: got addr %h instr %h pc %h op %h funct %h, want all 0",
                     bus.imem_addr, instr, instr_pc, op, funct);
        else n_pass++;
        rst = 1'b0;
        #1;
        n_total++;
        if (bus.imem_req !== 1'b1) $display("FAIL req_after_reset: got %b want 1", bus.imem_req);
        else n_pass++;
    endtask

    task automatic test_sequential();
        logic [31:0] w;
        logic        ev;
        do_reset(0);
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            #1;
            ev = (i % 2 == 0);
            n_total++;
            if (bus.imem_addr !== 32'(i / 2 * 4) || instr_valid !== ev)
                $display("FAIL seq_addr_valid[%0d]: got addr %h valid %b, want addr %h valid %b",
                         i, bus.imem_addr, instr_valid, 32'(i / 2 * 4), ev);
            else n_pass++;
            if (ev) begin
                w = memf(32'((i / 2 - 1) * 4));
                n_total++;
                if (instr_pc !== 32'((i / 2 - 1) * 4) || op !== w[31:26])
                    $display("FAIL seq_pc_op[%0d]: got pc %h op %h, want pc %h op %h",
                             i, instr_pc, op, 32'((i / 2 - 1) * 4), w[31:26]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_wait();
        logic        ev;
        logic [31:0] ea;
        do_reset(3);
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            #1;
            ev = (i == 5 || i == 10);
            ea = (i < 5) ? 32'd0 : ((i < 10) ? 32'd4 : 32'd8);
            n_total++;
            if (bus.imem_addr !== ea || instr_valid !== ev || bus.imem_req !== 1'b1)
                $display("FAIL wait[%0d]: got addr %h valid %b req %b, want addr %h valid %b req 1",
                         i, bus.imem_addr, instr_valid, bus.imem_req, ea, ev);
            else n_pass++;
            if (ev) begin
                n_total++;
                if (instr_pc !== ((i == 5) ? 32'd0 : 32'd4))
                    $display("FAIL wait_pc[%0d]: got %h want %h", i, instr_pc, (i == 5) ? 32'd0 : 32'd4);
                else n_pass++;
            end
        end
    endtask

    task automatic test_skid();
        do_reset(0);
        repeat (6) @(negedge clk);
        #1;
        n_total++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'd8 || bus.imem_addr !== 32'd12)
            $display("FAIL skid_pre: got valid %b pc %h addr %h, want 1 8 c", instr_valid, instr_pc, bus.imem_addr);
        else n_pass++;
        stall = 1'b1;
        @(negedge clk);
        #1;
        n_total++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'd8 || bus.imem_req !== 1'b1)
            $display("FAIL skid_hold: got valid %b pc %h req %b, want 1 8 1", instr_valid, instr_pc, bus.imem_req);
        else n_pass++;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            n_total++;
            if (bus.imem_req !== 1'b0 || instr_valid !== 1'b1 || instr_pc !== 32'd8)
                $display("FAIL skid_full[%0d]: got req %b valid %b pc %h, want 0 1 8", i, bus.imem_req, instr_valid, instr_pc);
            else n_pass++;
        end
        stall = 1'b0;
        @(negedge clk);
        #1;
        n_total++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'd12 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'd16)
            $display("FAIL skid_drain: got valid %b pc %h req %b addr %h, want 1 c 1 10",
                     instr_valid, instr_pc, bus.imem_req, bus.imem_addr);
        else n_pass++;
        @(negedge clk);
        #1;
        n_total++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'd16)
            $display("FAIL skid_resume: got valid %b pc %h, want 1 10", instr_valid, instr_pc);
        else n_pass++;
    endtask

    task automatic test_redirect_pending();
        int k;
        do_reset(2);
        k = 0;
        while (k < 60 && bus.imem_addr !== 32'd20) begin
            @(negedge clk);
            #1;
            k++;
        end
        n_total++;
        if (bus.imem_addr !== 32'd20) $display("FAIL rp_reach20: got addr %h want 14 (timeout)", bus.imem_addr);
        else n_pass++;
        @(negedge clk);
        #1;
        redirect = 1'b1;
        target = 32'h0000_0103;
        @(negedge clk);
        #1;
        redirect = 1'b0;
        n_total++;
        if (bus.imem_addr !== 32'd20 || bus.imem_req !== 1'b1 || instr_valid !== 1'b0)
            $display("FAIL rp_hold: got addr %h req %b valid %b, want 14 1 0", bus.imem_addr, bus.imem_req, instr_valid);
        else n_pass++;
        @(negedge clk);
        #1;
        n_total++;
        if (bus.imem_addr !== 32'd20) $display("FAIL rp_hold2: got addr %h want 14", bus.imem_addr);
        else n_pass++;
        @(negedge clk);
        #1;
        n_total++;
        if (bus.imem_addr !== 32'h100 || instr_valid !== 1'b0)
            $display("FAIL rp_newaddr: got addr %h valid %b, want 100 0", bus.imem_addr, instr_valid);
        else n_pass++;
        k = 0;
        while (k < 20 && instr_valid !== 1'b1) begin
            @(negedge clk);
            #1;
            k++;
        end
        n_total++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h100)
            $display("FAIL rp_first: got valid %b pc %h, want 1 100", instr_valid, instr_pc);
        else n_pass++;
    endtask

    task automatic test_redirect_skid();
        do_reset(0);
        repeat (6) @(negedge clk);
        #1;
        stall = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_total++;
        if (bus.imem_req !== 1'b0 || instr_valid !== 1'b1 || instr_pc !== 32'd8)
            $display("FAIL rs_full: got req %b valid %b pc %h, want 0 1 8", bus.imem_req, instr_valid, instr_pc);
        else n_pass++;
        redirect = 1'b1;
        target = 32'h0000_0203;
        @(negedge clk);
        #1;
        n_total++;
        if (instr_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h200)
            $display("FAIL rs_kill: got valid %b req %b addr %h, want 0 1 200", instr_valid, bus.imem_req, bus.imem_addr);
        else n_pass++;
        redirect = 1'b0;
        stall = 1'b0;
        @(negedge clk);
        #1;
        n_total++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h200)
            $display("FAIL rs_target: got valid %b pc %h, want 1 200", instr_valid, instr_pc);
        else n_pass++;
    endtask

    task automatic test_wrap();
        @(negedge clk);
        #1;
        rst_w = 1'b0;
        @(negedge clk);
        #1;
        n_total++;
        if (bus_w.imem_req !== 1'b1 || bus_w.imem_addr !== 32'hFFFF_FFFC)
            $display("FAIL wrap_first: got req %b addr %h, want 1 fffffffc", bus_w.imem_req, bus_w.imem_addr);
        else n_pass++;
        bus_w.imem_ready = 1'b1;
        bus_w.imem_rdata = 32'hABCD_1234;
        @(negedge clk);
        #1;
        bus_w.imem_ready = 1'b0;
        n_total++;
        if (instr_valid_w !== 1'b1 || instr_pc_w !== 32'hFFFF_FFFC || bus_w.imem_addr !== 32'h0)
            $display("FAIL wrap_next: got valid %b pc %h addr %h, want 1 fffffffc 0", instr_valid_w, instr_pc_w, bus_w.imem_addr);
        else n_pass++;
        n_total++;
        if (op_w !== 6'h2A || funct_w !== 6'h34)
            $display("FAIL wrap_fields: got op %h funct %h, want 2a 34", op_w, funct_w);
        else n_pass++;
        @(negedge clk);
        #1;
        n_total++;
        if (bus_w.imem_addr !== 32'h0 || bus_w.imem_req !== 1'b1 || instr_valid_w !== 1'b0)
            $display("FAIL wrap_wait: got addr %h req %b valid %b, want 0 1 0", bus_w.imem_addr, bus_w.imem_req, instr_valid_w);
        else n_pass++;
        rst_w = 1'b1;
        #1;
        n_total++;
        if (bus_w.imem_req !== 1'b0 || bus_w.imem_addr !== 32'hFFFF_FFFC || instr_valid_w !== 1'b0)
            $display("FAIL wrap_midreset: got req %b addr %h valid %b, want 0 fffffffc 0",
                     bus_w.imem_req, bus_w.imem_addr, instr_valid_w);
        else n_pass++;
        @(negedge clk);
        #1;
        rst_w = 1'b0;
        @(negedge clk);
        #1;
        n_total++;
        if (bus_w.imem_req !== 1'b1 || bus_w.imem_addr !== 32'hFFFF_FFFC)
            $display("FAIL wrap_refetch: got req %b addr %h, want 1 fffffffc", bus_w.imem_req, bus_w.imem_addr);
        else n_pass++;
    endtask

    task automatic test_random();
        logic        p_req, p_rdy;
        logic [31:0] p_addr;
        int          acc0;
        do_reset(1);
        acc0 = accepted;
        p_req = 1'b0;
        p_rdy = 1'b0;
        p_addr = 32'h0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            #1;
            if (p_req && !p_rdy && bus.imem_req) begin
                n_total++;
                if (bus.imem_addr !== p_addr)
                    $display("FAIL addr_stable[%0d]: got %h want %h", c, bus.imem_addr, p_addr);
                else n_pass++;
            end
            p_req = bus.imem_req;
            p_rdy = bus.imem_ready;
            p_addr = bus.imem_addr;
            stall = ($urandom_range(0, 99) < 30);
            redirect = ($urandom_range(0, 99) < 4);
            target = $urandom;
            lat = $urandom_range(0, 3);
        end
        @(negedge clk);
        #1;
        stall = 1'b0;
        redirect = 1'b0;
        n_total++;
        if (accepted - acc0 < 200)
            $display("FAIL random_progress: got %0d accepted want >= 200", accepted - acc0);
        else n_pass++;
    endtask

    initial begin
        rst = 1'b1;
        stall = 1'b0;
        redirect = 1'b0;
        target = 32'h0;
        lat = 0;
        rst_w = 1'b1;
        bus_w.imem_ready = 1'b0;
        bus_w.imem_rdata = 32'h0;
        n_pass = 0;
        n_total = 0;
        accepted = 0;
        exp_pc = 32'h0;
        fork
            sb_loop();
        join_none
        test_reset();
        test_sequential();
        test_wait();
        test_skid();
        test_redirect_pending();
        test_redirect_skid();
        test_wrap();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
